// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package piso_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bit counter width: enough to index WIDTH bits, never narrower than 1.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_shreg.sv
// WIDTH-bit load/shift register; bit_out is the MSB (dir=1) or LSB (dir=0) of the held word.
// Latency: load or shift takes effect at the next rising edge; bit_out comes straight from a flop.
// Backpressure: none; load has priority over shift, and vacated bits fill with zero.
module piso_shreg
    import piso_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    output logic             bit_out
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Next word: capture on load, else move toward the output end with zero fill.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = d;
        end else if (shift) begin
            sr_d = dir ? (sr_q << 1) : (sr_q >> 1);
        end
    end

    // Word register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bit_out = dir ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a word on valid/ready, sends it one bit per clock with first/last strobes.
// Latency: first bit visible 1 cycle after the accept edge; a frame lasts exactly WIDTH cycles.
// Backpressure: load_ready is low while a frame is mid-flight and rises on its last bit, allowing gapless frames.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] I_par,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic [CNT_W-1:0] frame_count
);

    localparam int CW = cnt_width(WIDTH);
    // Counter value of the bit just before the last one.
    localparam logic [CW-1:0] PRE_LAST = CW'((WIDTH > 1) ? (WIDTH - 2) : 0);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             sr_load;
    logic             sr_shift;
    logic             accept;

    assign load_ready = (state_q == IDLE) || (state_q == SHIFT && last_q);
    assign accept     = load_valid && load_ready;

    // Next-state, framing strobes and shift-register control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        first_d  = 1'b0;
        last_d   = last_q;
        fcnt_d   = fcnt_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    first_d = 1'b1;
                    last_d  = (WIDTH == 1);
                    sr_load = 1'b1;
                end
            end
            SHIFT: begin
                if (last_q) begin
                    fcnt_d = fcnt_q + CNT_W'(1);
                    if (accept) begin
                        cnt_d   = '0;
                        first_d = 1'b1;
                        last_d  = (WIDTH == 1);
                        sr_load = 1'b1;
                    end else begin
                        // The final shift pushes out the last bit, leaving ser_out at 0.
                        state_d  = IDLE;
                        cnt_d    = '0;
                        valid_d  = 1'b0;
                        last_d   = 1'b0;
                        sr_shift = 1'b1;
                    end
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    last_d   = (cnt_q == PRE_LAST);
                    sr_shift = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and framing registers; reset drops any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            fcnt_q  <= fcnt_d;
        end
    end

    piso_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load    (sr_load),
        .shift   (sr_shift),
        .d       (I_par),
        .dir     (MSB_FIRST != 0),
        .bit_out (ser_out)
    );

    assign ser_valid   = valid_q;
    assign ser_first   = first_q;
    assign ser_last    = last_q;
    assign frame_count = fcnt_q;

endmodule
